// File: rtl/gpio_apb_arbiter.sv
// Round-robin arbiter that serialises single-register transactions from NUM_REQ
// requesters onto the GPIO APB slave port, filtering addresses the GPIO does not decode.
module gpio_apb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int PORT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      psuberr
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, CAPTURE, REJECT} state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_found;
    logic               sel_write;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               addr_ok;
    logic               suberr_prev;
    logic [DATA_W-1:0]  rdata_fwd;
    int unsigned        cand;

    // First asserted request at or after the round-robin pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NUM_REQ)
                cand = cand - NUM_REQ;
            if (!grant_found && req[IDX_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
        addr_ok = (sel_addr == '0) || (sel_addr == ADDR_W'(1)) ||
                  (!sel_write && sel_addr == ADDR_W'(2));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            winner      <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            done        <= '0;
            suberr_prev <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        winner <= grant_idx;
                        ptr    <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        pwrite <= sel_write;
                        paddr  <= sel_addr;
                        pwdata <= sel_wdata;
                        if (addr_ok) begin
                            psel  <= 1'b1;
                            state <= SETUP;
                        end else begin
                            done[grant_idx] <= 1'b1;
                            state           <= REJECT;
                        end
                    end
                end
                SETUP: begin
                    suberr_prev <= psuberr;
                    penable     <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    psel         <= 1'b0;
                    penable      <= 1'b0;
                    done[winner] <= 1'b1;
                    state        <= CAPTURE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    generate
        if (PORT_W < DATA_W) begin : g_wide
            assign rdata_fwd = {prdata[DATA_W-1:PORT_W], prdata[PORT_W-1:0]};
        end else begin : g_narrow
            assign rdata_fwd = prdata;
        end
    endgenerate

    // prdata/psuberr only settle in the cycle after ACCESS, so the response is decoded from state.
    assign rsp_rdata = (state == CAPTURE && !pwrite) ? rdata_fwd : '0;
    assign rsp_err   = (state == CAPTURE) ? (psuberr & ~suberr_prev) : (state == REJECT);

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Scoreboard bench for gpio_apb_arbiter with a small behavioural GPIO slave
// (addr 0 = direction, addr 1 = output data, addr 2 = pin readback).
module tb_gpio_apb_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = '0;
    logic [3:0]   req_write = '0;
    logic [127:0] req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic [3:0]   done;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic         psel, penable, pwrite;
    logic [31:0]  paddr, pwdata;
    logic [31:0]  prdata = '0;
    logic         psuberr = 1'b0;

    logic [31:0]  gpio_ddr = '0;
    logic [31:0]  gpio_dout = '0;
    logic [15:0]  pins = '0;
    logic         inj = 1'b0;
    logic [3:0]   hold = '0;

    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;
    int           pcnt = 0;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          npsel;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    gpio_apb_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .PORT_W(16)) dut (
        .clk(clk), .reset(rst), .req(req), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .psuberr(psuberr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (psel && penable) begin
            if (pwrite) begin
                case (paddr)
                    32'd0:   gpio_ddr  <= pwdata;
                    32'd1:   gpio_dout <= pwdata;
                    default: psuberr   <= 1'b1;
                endcase
            end else begin
                case (paddr)
                    32'd0:   prdata <= gpio_ddr;
                    32'd1:   prdata <= gpio_dout;
                    32'd2:   prdata <= {16'h0, (pins & ~gpio_ddr[15:0]) | (gpio_dout[15:0] & gpio_ddr[15:0])};
                    default: psuberr <= 1'b1;
                endcase
            end
            if (inj)
                psuberr <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
        n_vec++;
        if (act !== req_v) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req_v);
        end
    endtask

    // Requesters drop req on their done unless held for back-to-back service.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (done[i] && !hold[i])
                req[i] = 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            pcnt = 0;
        end else begin
            if (psel)
                pcnt++;
            if (penable)
                chk("penable_without_psel", 64'(psel), 64'(1));
            if (done != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("done_onehot", 64'(done), 64'(4'b0001 << e.idx));
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("psel_cycles", 64'(pcnt), 64'(e.npsel));
                end
                pcnt = 0;
            end
        end
    end

    task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        req_write[i]         = w;
        req_addr[i*32 +: 32] = a;
        req_wdata[i*32 +: 32] = d;
        req[i]               = 1'b1;
    endtask

    task automatic expect_done(input int i, input logic [31:0] rd, input logic er, input int c, input int np);
        exp_t x;
        x.idx = i; x.rdata = rd; x.err = er; x.cyc = c; x.npsel = np;
        sb.push_back(x);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || req != '0) && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("drain_pending", 64'(sb.size()), 64'(0));
        sb.delete();
        req = '0;
    endtask

    task automatic txn(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input logic er, input logic valid);
        @(negedge clk);
        set_req(i, w, a, d);
        expect_done(i, rd, er, cyc + (valid ? 3 : 1), valid ? 2 : 0);
        wait_drain();
    endtask

    initial begin
        int c;
        repeat (3) @(negedge clk);
        chk("reset_psel", 64'(psel), 64'(0));
        chk("reset_penable", 64'(penable), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_paddr_pwdata_pwrite", {pwdata, paddr} | 64'(pwrite), 64'(0));
        chk("reset_rsp", 64'(rsp_rdata) | 64'(rsp_err), 64'(0));
        rst = 1'b0;

        txn(0, 1'b1, 32'd1, 32'h0000_00FF, 32'h0, 1'b0, 1'b1);
        txn(0, 1'b0, 32'd1, 32'h0, 32'h0000_00FF, 1'b0, 1'b1);
        pins = 16'hA5A5;
        txn(2, 1'b0, 32'd2, 32'h0, 32'h0000_A5A5, 1'b0, 1'b1);
        txn(0, 1'b1, 32'd1, 32'hCAFE_0055, 32'h0, 1'b0, 1'b1);
        txn(0, 1'b0, 32'd1, 32'h0, 32'hCAFE_0055, 1'b0, 1'b1);

        txn(1, 1'b1, 32'd2, 32'h1234, 32'h0, 1'b1, 1'b0);
        txn(1, 1'b0, 32'd3, 32'h0, 32'h0, 1'b1, 1'b0);
        txn(1, 1'b0, 32'h8000_0001, 32'h0, 32'h0, 1'b1, 1'b0);
        txn(1, 1'b1, 32'h0001_0000, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("psuberr_after_rejects", 64'(psuberr), 64'(0));

        // Pointer is 2 here; req[0] wins by wrapping, then req[3] arrives during ACCESS.
        @(negedge clk);
        c = cyc;
        set_req(0, 1'b0, 32'd1, 32'h0);
        expect_done(0, 32'hCAFE_0055, 1'b0, c + 3, 2);
        repeat (2) @(negedge clk);
        set_req(3, 1'b0, 32'd2, 32'h0);
        expect_done(3, 32'h0000_A5A5, 1'b0, c + 7, 2);
        wait_drain();

        // Write to direction register abandoned by reset during ACCESS.
        @(negedge clk);
        set_req(0, 1'b1, 32'd0, 32'h0000_00F0);
        repeat (2) @(negedge clk);
        chk("in_access_before_reset", {62'h0, psel, penable}, 64'h3);
        #2 rst = 1'b1;
        req = '0;
        #1;
        chk("reset_mid_psel", 64'(psel), 64'(0));
        chk("reset_mid_penable", 64'(penable), 64'(0));
        chk("reset_mid_done", 64'(done), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        c = cyc;
        set_req(1, 1'b0, 32'd0, 32'h0);
        set_req(0, 1'b0, 32'd0, 32'h0);
        expect_done(0, 32'h0, 1'b0, c + 3, 2);
        expect_done(1, 32'h0, 1'b0, c + 7, 2);
        wait_drain();

        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        c = cyc;
        hold = 4'hF;
        for (int i = 0; i < 4; i++)
            set_req(i, 1'b0, 32'd1, 32'h0);
        for (int k = 0; k < 5; k++)
            expect_done(k % 4, 32'hCAFE_0055, 1'b0, c + 3 + 4 * k, 2);
        repeat (19) @(negedge clk);
        req  = '0;
        hold = '0;
        wait_drain();

        inj = 1'b1;
        txn(2, 1'b0, 32'd1, 32'h0, 32'hCAFE_0055, 1'b1, 1'b1);
        inj = 1'b0;
        txn(2, 1'b0, 32'd1, 32'h0, 32'hCAFE_0055, 1'b0, 1'b1);
        chk("psuberr_sticky", 64'(psuberr), 64'(1));

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
